// File: rtl/uart_stream_loader.sv
// uart_stream_loader: runs a fixed command/handshake exchange over a byte-wide
// UART interface. It then streams the coefficient memory and the sample memory
// out most-significant byte first, and finally waits for the filter to report
// completion. Every response wait is bounded by a saturating timeout counter.
module uart_stream_loader #(
  parameter int WORD_W     = 16,
  parameter int COEF_DEPTH = 64,
  parameter int DATA_DEPTH = 1024,
  parameter int TIMEOUT    = 4096,
  localparam int MAX_DEPTH = (COEF_DEPTH > DATA_DEPTH) ? COEF_DEPTH : DATA_DEPTH,
  localparam int AW        = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  output logic              MEM_SEL,
  output logic [AW-1:0]     MEM_ADDR,
  input  logic [WORD_W-1:0] MEM_RDATA,
  output logic [7:0]        TX_BYTE,
  output logic              TX_VALID,
  input  logic              TX_ACK,
  input  logic [7:0]        RSP_BYTE,
  input  logic              RSP_VALID,
  input  logic              FILTER_COMPLETE,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [2:0]        ERR_CODE
);

  localparam int NB = WORD_W / 8;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] COEF_LAST = AW'(COEF_DEPTH - 1);
  localparam logic [AW-1:0] DATA_LAST = AW'(DATA_DEPTH - 1);
  localparam logic [2:0]    BYTE_LAST = 3'(NB - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_SAT    = TW'(TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, CMD, CMD_WT, HS, HS_WT, COEF, COEF_WT, DATA, DATA_WT, FILT, DONE_S, ERR_S
  } state_e;

  // Per-word sub-steps: present address, latch read data, send byte, idle gap.
  typedef enum logic [1:0] {SP_ADDR, SP_LATCH, SP_SEND, SP_GAP} sub_e;

  state_e              state_q, state_d;
  sub_e                sub_q, sub_d;
  logic [AW-1:0]       k_q, k_d;
  logic                mem_sel_q, mem_sel_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [2:0]          byte_idx_q, byte_idx_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                tx_valid_q, tx_valid_d;
  logic [TW-1:0]       to_cnt_q, to_cnt_d;
  logic                err_q, err_d;
  logic [2:0]          err_code_q, err_code_d;

  // Per wait-state decode: expected response, success target and phase code.
  logic [7:0]          exp_byte;
  state_e              ok_state;
  logic [2:0]          phase_code;
  logic                go_err;
  logic [AW-1:0]       last_k;

  // State and datapath registers, cleared asynchronously so a reset aborts any byte in flight.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      sub_q      <= SP_ADDR;
      k_q        <= '0;
      mem_sel_q  <= 1'b0;
      word_q     <= '0;
      byte_idx_q <= '0;
      tx_byte_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
      err_code_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      sub_q      <= sub_d;
      k_q        <= k_d;
      mem_sel_q  <= mem_sel_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Next-state logic: handshake sequencing, word streaming and timeout handling.
  always_comb begin
    state_d    = state_q;
    sub_d      = sub_q;
    k_d        = k_q;
    mem_sel_d  = mem_sel_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = tx_valid_q;
    to_cnt_d   = to_cnt_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    go_err     = 1'b0;
    exp_byte   = 8'h00;
    ok_state   = IDLE;
    phase_code = 3'd0;
    last_k     = mem_sel_q ? DATA_LAST : COEF_LAST;

    case (state_q)
      CMD_WT:  begin exp_byte = 8'h46; ok_state = HS;   phase_code = 3'd1; end
      HS_WT:   begin exp_byte = 8'h61; ok_state = COEF; phase_code = 3'd2; end
      COEF_WT: begin exp_byte = 8'h72; ok_state = DATA; phase_code = 3'd3; end
      DATA_WT: begin exp_byte = 8'h69; ok_state = FILT; phase_code = 3'd4; end
      FILT:    begin phase_code = 3'd5; end
      default: ;
    endcase

    case (state_q)
      IDLE: begin
        if (START) begin
          err_d      = 1'b0;
          err_code_d = 3'd0;
          k_d        = '0;
          mem_sel_d  = 1'b0;
          tx_valid_d = 1'b1;
          tx_byte_d  = 8'h39;
          state_d    = CMD;
        end
      end
      CMD, HS: begin
        if (TX_ACK) begin
          tx_valid_d = 1'b0;
          state_d    = (state_q == CMD) ? CMD_WT : HS_WT;
        end
      end
      CMD_WT, HS_WT, COEF_WT, DATA_WT: begin
        // A response byte wins over a timeout expiring in the same cycle.
        if (RSP_VALID) begin
          if (RSP_BYTE == exp_byte) begin
            state_d = ok_state;
            case (ok_state)
              HS:      begin tx_valid_d = 1'b1; tx_byte_d = 8'h68; end
              COEF:    begin k_d = '0; mem_sel_d = 1'b0; sub_d = SP_ADDR; end
              DATA:    begin k_d = '0; mem_sel_d = 1'b1; sub_d = SP_ADDR; end
              default: ;
            endcase
          end else begin
            go_err = 1'b1;
          end
        end else if (to_cnt_q >= TO_LAST) begin
          go_err = 1'b1;
        end else if (to_cnt_q != TO_SAT) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      COEF, DATA: begin
        case (sub_q)
          SP_ADDR:  sub_d = SP_LATCH;
          SP_LATCH: begin
            word_d     = MEM_RDATA;
            tx_byte_d  = MEM_RDATA[WORD_W-1 -: 8];
            tx_valid_d = 1'b1;
            byte_idx_d = '0;
            sub_d      = SP_SEND;
          end
          SP_SEND: begin
            if (TX_ACK) begin
              tx_valid_d = 1'b0;
              if (byte_idx_q == BYTE_LAST) begin
                if (k_q == last_k) begin
                  state_d = mem_sel_q ? DATA_WT : COEF_WT;
                end else begin
                  k_d   = k_q + 1'b1;
                  sub_d = SP_ADDR;
                end
              end else begin
                byte_idx_d = byte_idx_q + 1'b1;
                word_d     = word_q << 8;
                sub_d      = SP_GAP;
              end
            end
          end
          SP_GAP: begin
            tx_valid_d = 1'b1;
            tx_byte_d  = word_q[WORD_W-1 -: 8];
            sub_d      = SP_SEND;
          end
          default: sub_d = SP_ADDR;
        endcase
      end
      FILT: begin
        if (FILTER_COMPLETE) begin
          state_d = DONE_S;
        end else if (to_cnt_q >= TO_LAST) begin
          go_err = 1'b1;
        end else if (to_cnt_q != TO_SAT) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      DONE_S: state_d = IDLE;
      ERR_S: begin
        tx_valid_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (go_err) begin
      state_d    = ERR_S;
      err_d      = 1'b1;
      err_code_d = phase_code;
      tx_valid_d = 1'b0;
    end

    // Every wait state starts counting from zero.
    if (state_d != state_q) begin
      to_cnt_d = '0;
    end
  end

  assign MEM_SEL  = mem_sel_q;
  assign MEM_ADDR = k_q;
  assign TX_BYTE  = tx_byte_q;
  assign TX_VALID = tx_valid_q;
  assign BUSY     = (state_q != IDLE);
  assign DONE     = (state_q == DONE_S);
  assign ERR      = err_q;
  assign ERR_CODE = err_code_q;

endmodule

// File: tb/tb_uart_stream_loader.sv
// Directed bench for uart_stream_loader: a default-parameter instance
// (nominal run, mismatch, TX stall, mid-run reset) and a 24-bit / TIMEOUT=16
// instance (byte ordering, data-wait timeout).
module tb_uart_stream_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance 0: defaults
  logic        start0, tx_ack0, rsp_valid0, filt0;
  logic [7:0]  rsp_byte0, tx_byte0;
  logic        mem_sel0, tx_valid0, busy0, done0, err0;
  logic [9:0]  mem_addr0;
  logic [15:0] mem_rdata0;
  logic [2:0]  err_code0;

  // Instance 1: WORD_W=24, COEF_DEPTH=4, DATA_DEPTH=8, TIMEOUT=16
  logic        start1, tx_ack1, rsp_valid1, filt1;
  logic [7:0]  rsp_byte1, tx_byte1;
  logic        mem_sel1, tx_valid1, busy1, done1, err1;
  logic [2:0]  mem_addr1;
  logic [23:0] mem_rdata1;
  logic [2:0]  err_code1;

  logic [15:0] coef0 [64];
  logic [15:0] data0 [1024];
  logic [23:0] coef1 [4];
  logic [23:0] data1 [8];

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  int done_cnt0 = 0;
  int done_cnt1 = 0;

  int total = 0;
  int bad = 0;
  int mism, early, cnt;

  uart_stream_loader dut0 (
    .CLK(clk), .RESET_N(rst_n), .START(start0), .MEM_SEL(mem_sel0),
    .MEM_ADDR(mem_addr0), .MEM_RDATA(mem_rdata0), .TX_BYTE(tx_byte0),
    .TX_VALID(tx_valid0), .TX_ACK(tx_ack0), .RSP_BYTE(rsp_byte0),
    .RSP_VALID(rsp_valid0), .FILTER_COMPLETE(filt0), .BUSY(busy0),
    .DONE(done0), .ERR(err0), .ERR_CODE(err_code0)
  );

  uart_stream_loader #(.WORD_W(24), .COEF_DEPTH(4), .DATA_DEPTH(8), .TIMEOUT(16)) dut1 (
    .CLK(clk), .RESET_N(rst_n), .START(start1), .MEM_SEL(mem_sel1),
    .MEM_ADDR(mem_addr1), .MEM_RDATA(mem_rdata1), .TX_BYTE(tx_byte1),
    .TX_VALID(tx_valid1), .TX_ACK(tx_ack1), .RSP_BYTE(rsp_byte1),
    .RSP_VALID(rsp_valid1), .FILTER_COMPLETE(filt1), .BUSY(busy1),
    .DONE(done1), .ERR(err1), .ERR_CODE(err_code1)
  );

  // Synchronous-read memories: data valid one cycle after the address.
  always @(posedge clk) begin
    mem_rdata0 <= mem_sel0 ? data0[mem_addr0] : coef0[mem_addr0[5:0]];
    mem_rdata1 <= mem_sel1 ? data1[mem_addr1] : coef1[mem_addr1[1:0]];
  end

  // Capture every byte that will be accepted at the coming rising edge.
  always @(negedge clk) begin
    if (tx_valid0 && tx_ack0) q0.push_back(tx_byte0);
    if (tx_valid1 && tx_ack1) q1.push_back(tx_byte1);
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Returns at negedge+1 of the cycle whose rising edge accepts byte number n.
  task automatic wait_bytes(input int inst, input int n);
    int cyc;
    cyc = 0;
    while (((inst == 0) ? q0.size() : q1.size()) < n && cyc < 20000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check($sformatf("bytes%0d_reach_%0d", inst, n),
          32'(((inst == 0) ? q0.size() : q1.size()) >= n), 32'd1);
  endtask

  task automatic send_rsp(input int inst, input logic [7:0] b);
    @(posedge clk);
    #1;
    if (inst == 0) begin rsp_valid0 = 1'b1; rsp_byte0 = b; end
    else begin rsp_valid1 = 1'b1; rsp_byte1 = b; end
    @(posedge clk);
    #1;
    rsp_valid0 = 1'b0;
    rsp_valid1 = 1'b0;
  endtask

  task automatic pulse_start(input int inst);
    if (inst == 0) start0 = 1'b1;
    else start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) coef0[i] = 16'hC000 | 16'(i * 3);
    for (int i = 0; i < 1024; i++) data0[i] = 16'h5000 ^ 16'(i * 7);
    for (int i = 0; i < 4; i++) coef1[i] = 24'hABCDEF + 24'(i);
    for (int i = 0; i < 8; i++) data1[i] = 24'h102030 + 24'(i * 24'h010101);

    exp0.push_back(8'h39);
    exp0.push_back(8'h68);
    for (int i = 0; i < 64; i++) for (int b = 1; b >= 0; b--) exp0.push_back(coef0[i][b*8 +: 8]);
    for (int i = 0; i < 1024; i++) for (int b = 1; b >= 0; b--) exp0.push_back(data0[i][b*8 +: 8]);
    exp1.push_back(8'h39);
    exp1.push_back(8'h68);
    for (int i = 0; i < 4; i++) for (int b = 2; b >= 0; b--) exp1.push_back(coef1[i][b*8 +: 8]);
    for (int i = 0; i < 8; i++) for (int b = 2; b >= 0; b--) exp1.push_back(data1[i][b*8 +: 8]);

    rst_n = 1'b0;
    start0 = 1'b0; tx_ack0 = 1'b1; rsp_valid0 = 1'b0; rsp_byte0 = 8'h00; filt0 = 1'b0;
    start1 = 1'b0; tx_ack1 = 1'b1; rsp_valid1 = 1'b0; rsp_byte1 = 8'h00; filt1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs0", 32'({tx_valid0, tx_byte0, mem_sel0, mem_addr0, busy0, done0, err0, err_code0}), 32'd0);
    check("reset_outputs1", 32'({tx_valid1, tx_byte1, mem_sel1, mem_addr1, busy1, done1, err1, err_code1}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 24-bit words, byte order and data-wait timeout
    pulse_start(1);
    check("busy1_after_start", 32'(busy1), 32'd1);
    wait_bytes(1, 1);
    send_rsp(1, 8'h46);
    wait_bytes(1, 2);
    send_rsp(1, 8'h61);
    wait_bytes(1, 14);
    send_rsp(1, 8'h72);
    wait_bytes(1, 38);
    @(posedge clk);
    early = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (err1 !== 1'b0) early++;
    end
    check("w24_no_err_before_16", 32'(early), 32'd0);
    @(posedge clk);
    #1;
    check("w24_timeout_err", 32'(err1), 32'd1);
    check("w24_timeout_code", 32'(err_code1), 32'd4);
    @(posedge clk);
    #1;
    check("w24_idle_after_err", 32'(busy1), 32'd0);
    check("w24_total_bytes", 32'(q1.size()), 32'd38);
    check("w24_byte2", 32'(q1[2]), 32'hAB);
    check("w24_byte3", 32'(q1[3]), 32'hCD);
    check("w24_byte4", 32'(q1[4]), 32'hEF);
    mism = 0;
    for (int i = 0; i < exp1.size(); i++) if (i >= q1.size() || q1[i] !== exp1[i]) mism++;
    check("w24_stream_mismatches", 32'(mism), 32'd0);

    // Nominal run, defaults, TX_ACK tied high
    q0.delete();
    pulse_start(0);
    check("nom_busy", 32'(busy0), 32'd1);
    wait_bytes(0, 1);
    send_rsp(0, 8'h46);
    wait_bytes(0, 2);
    send_rsp(0, 8'h61);
    wait_bytes(0, 130);
    send_rsp(0, 8'h72);
    wait_bytes(0, 2178);
    send_rsp(0, 8'h69);
    filt0 = 1'b1;
    @(posedge clk);
    #1;
    check("nom_done_high", 32'(done0), 32'd1);
    filt0 = 1'b0;
    @(posedge clk);
    #1;
    check("nom_done_low", 32'(done0), 32'd0);
    check("nom_idle", 32'(busy0), 32'd0);
    check("nom_no_err", 32'(err0), 32'd0);
    check("nom_done_pulses", 32'(done_cnt0), 32'd1);
    check("nom_total_bytes", 32'(q0.size()), 32'd2178);
    check("nom_byte0", 32'(q0[0]), 32'h39);
    check("nom_byte1", 32'(q0[1]), 32'h68);
    check("nom_byte2", 32'(q0[2]), 32'hC0);
    check("nom_byte3", 32'(q0[3]), 32'h00);
    check("nom_byte4", 32'(q0[4]), 32'hC0);
    mism = 0;
    for (int i = 0; i < exp0.size(); i++) if (i >= q0.size() || q0[i] !== exp0[i]) mism++;
    check("nom_stream_mismatches", 32'(mism), 32'd0);

    // Wrong command response
    q0.delete();
    pulse_start(0);
    wait_bytes(0, 1);
    send_rsp(0, 8'h47);
    check("mis_err_set", 32'(err0), 32'd1);
    @(posedge clk);
    #1;
    check("mis_err", 32'(err0), 32'd1);
    check("mis_code", 32'(err_code0), 32'd1);
    check("mis_busy_low", 32'(busy0), 32'd0);

    // TX_ACK stalled for 10 cycles on the command byte
    q0.delete();
    tx_ack0 = 1'b0;
    pulse_start(0);
    check("stall_err_cleared", 32'({err0, err_code0}), 32'd0);
    mism = 0;
    repeat (10) begin
      if (!(tx_valid0 === 1'b1 && tx_byte0 === 8'h39)) mism++;
      @(posedge clk);
      #1;
    end
    check("stall_byte_held", 32'(mism), 32'd0);
    check("stall_nothing_accepted", 32'(q0.size()), 32'd0);
    tx_ack0 = 1'b1;
    @(posedge clk);
    #1;
    check("stall_valid_drops", 32'(tx_valid0), 32'd0);
    check("stall_single_accept", 32'(q0.size()), 32'd1);
    check("stall_byte_value", 32'(q0[0]), 32'h39);
    send_rsp(0, 8'h46);
    wait_bytes(0, 2);
    send_rsp(0, 8'h61);

    // Reset in the middle of the coefficient phase at k=30
    wait_bytes(0, 62);
    @(posedge clk);
    #1;
    check("rst_k30_addr", 32'(mem_addr0), 32'd30);
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", 32'({tx_valid0, tx_byte0, mem_sel0, mem_addr0, busy0, done0, err0, err_code0}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt = q0.size();
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_resend", 32'(q0.size() - cnt), 32'd0);
    check("rst_stays_idle", 32'({busy0, tx_valid0}), 32'd0);
    q0.delete();
    pulse_start(0);
    wait_bytes(0, 1);
    check("rst_restart_byte", 32'(q0[0]), 32'h39);
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
